// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   M-stage load/store unit. It turns a single load or store from the
//   pipeline into one request on a simple valid/ready memory bus. It stalls
//   the pipeline while the access is outstanding. On completion it formats
//   load data (lane select plus sign or zero extension). A stuck bus is
//   abandoned after TIMEOUT_CYCLES busy cycles and reported on BusErrM.
//
//   Access sequence: IDLE -> BUSY (one or more cycles) -> DONE -> IDLE.
//   The pipeline advances on the edge that ends DONE.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum BUSY cycles without MemReady (0 = no timeout)
//
// Build option:
//   MISALIGN_TRAP_EN  when defined, misaligned halfword and word accesses are
//                     not issued and are reported on MisalignM. When it is
//                     undefined, MisalignM is 0, halfword lanes use addr[1]
//                     only, and word accesses ignore addr[1:0].
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous reset, active low
//   MemReadM    M-stage load
//   MemWriteM   M-stage store (takes priority when both are set)
//   Funct3M     size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu, other -> w
//   ALUResultM  effective byte address
//   WriteDataM  store data, right-aligned
//   ReadDataM   extended load data (held between loads)
//   StallM      pipeline stall request
//   BusErrM     one-cycle pulse: access aborted by timeout
//   MisalignM   one-cycle pulse: misaligned access rejected
//   MemAddr     word-aligned bus address
//   MemWData    lane-replicated store data
//   MemBE       byte enables
//   MemWE       1 = write, 0 = read
//   MemValid    request valid
//   MemReady    bus handshake
//   MemRData    bus read data
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        MisalignM,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  output logic        MemWE,
  output logic        MemValid,
  input  logic        MemReady,
  input  logic [31:0] MemRData
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam logic        TO_EN    = (TO_LIMIT != 32'd0);
  localparam logic [31:0] TO_LAST  = TO_LIMIT - 32'd1;

  // Access size from Funct3M. Unsupported encodings are treated as word.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    logic [1:0] s;
    case (f3)
      3'b000, 3'b100: s = SZ_B;
      3'b001, 3'b101: s = SZ_H;
      default:        s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = 4'b0011 << {lane[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      SZ_B:    r = {4{wd[7:0]}};
      SZ_H:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lane, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (size)
      SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  logic [1:0]  state_q,    state_d;
  logic [31:0] cnt_q,      cnt_d;
  logic [31:0] rdata_q,    rdata_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [3:0]  be_q,       be_d;
  logic        we_q,       we_d;
  logic        load_q,     load_d;
  logic [1:0]  size_q,     size_d;
  logic        uns_q,      uns_d;
  logic [1:0]  lane_q,     lane_d;
  logic        buserr_q,   buserr_d;
  logic        misalign_q, misalign_d;

  logic        req_s;
  logic [1:0]  size_s;
  logic        mis_s;

  assign req_s  = MemReadM | MemWriteM;
  assign size_s = size_of(Funct3M);

`ifdef MISALIGN_TRAP_EN
  assign mis_s = ((size_s == SZ_H) && ALUResultM[0]) ||
                 ((size_s == SZ_W) && (ALUResultM[1:0] != 2'b00));
`else
  assign mis_s = 1'b0;
`endif

  // Next-state logic for the access FSM and its captured bus fields.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    load_d     = load_q;
    size_d     = size_q;
    uns_d      = uns_q;
    lane_d     = lane_q;
    buserr_d   = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s && mis_s) begin
          // Rejected without touching the bus.
          state_d    = ST_DONE;
          misalign_d = 1'b1;
        end else if (req_s) begin
          state_d = ST_BUSY;
          cnt_d   = 32'd0;
          addr_d  = {ALUResultM[31:2], 2'b00};
          lane_d  = ALUResultM[1:0];
          size_d  = size_s;
          uns_d   = Funct3M[2];
          // A simultaneous load and store performs only the store.
          load_d  = MemReadM & ~MemWriteM;
          we_d    = MemWriteM;
          be_d    = store_be(size_s, ALUResultM[1:0]);
          wdata_d = store_wdata(size_s, WriteDataM);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (MemReady) begin
          state_d = ST_DONE;
          if (load_q) begin
            rdata_d = load_fmt(size_q, uns_q, lane_q, MemRData);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          // Timeout on the last allowed busy cycle.
          state_d  = ST_DONE;
          buserr_d = 1'b1;
          if (load_q) begin
            rdata_d = 32'd0;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bus-field registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 32'd0;
      rdata_q    <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      we_q       <= 1'b0;
      load_q     <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      lane_q     <= 2'd0;
      buserr_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      load_q     <= load_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      lane_q     <= lane_d;
      buserr_q   <= buserr_d;
      misalign_q <= misalign_d;
    end
  end

  // Stall decode. The stall rises in IDLE as soon as a request appears, so
  // the pipeline never advances past an unissued access.
  always_comb begin
    StallM = 1'b0;
    case (state_q)
      ST_IDLE: StallM = req_s;
      ST_BUSY: StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
  end

  assign MemValid  = (state_q == ST_BUSY);
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  assign MemBE     = be_q;
  assign MemWE     = we_q;
  assign ReadDataM = rdata_q;
  assign BusErrM   = buserr_q;

`ifdef MISALIGN_TRAP_EN
  assign MisalignM = misalign_q;
`else
  assign MisalignM = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Purpose:
//   Self-checking bench for load_store_unit with TIMEOUT_CYCLES=4.
//   Stores, loads of every size, unsupported sizes and a combined load and
//   store come from a vector table. Hand-written sequences cover MemReady
//   outside BUSY, misalignment, reset in the middle of an access, and the
//   timeout. Expected bus fields and load results are pushed to a queue when
//   a request is driven, and they are popped at the bus handshake.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic        we;
    logic [31:0] rdm;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        BusErrM;
  logic        MisalignM;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        MemWE;
  logic        MemValid;
  logic        MemReady;
  logic [31:0] MemRData;

  int   n_pass;
  int   n_total;
  vec_t exp_q[$];
  vec_t vecs[12];

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .BusErrM    (BusErrM),
    .MisalignM  (MisalignM),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemBE      (MemBE),
    .MemWE      (MemWE),
    .MemValid   (MemValid),
    .MemReady   (MemReady),
    .MemRData   (MemRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle_inputs();
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    Funct3M    = 3'b000;
    ALUResultM = 32'd0;
    WriteDataM = 32'd0;
    MemReady   = 1'b0;
  endtask

  // One full access. Inputs are driven 1 time unit after the rising edge and
  // outputs are sampled on the falling edge.
  task automatic run_txn(input int idx, input vec_t v);
    vec_t e;
    bit   got;
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    Funct3M    = v.f3;
    ALUResultM = v.addr;
    WriteDataM = v.wd;
    MemRData   = v.rdata;
    MemReady   = 1'b0;
    exp_q.push_back(v);
    @(negedge clk);
    chk($sformatf("v%0d idle_stall", idx), {31'd0, StallM}, 32'd1);
    chk($sformatf("v%0d idle_valid", idx), {31'd0, MemValid}, 32'd0);
    @(posedge clk); #1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      MemReady = (c == v.lat);
      @(negedge clk);
      chk($sformatf("v%0d busy_valid c%0d", idx, c), {31'd0, MemValid}, 32'd1);
      chk($sformatf("v%0d busy_stall c%0d", idx, c), {31'd0, StallM}, 32'd1);
      if (MemReady) begin
        got = 1'b1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d addr", idx), MemAddr, {e.addr[31:2], 2'b00});
        chk($sformatf("v%0d we", idx), {31'd0, MemWE}, {31'd0, e.we});
        if (e.wr) begin
          chk($sformatf("v%0d be", idx), {28'd0, MemBE}, {28'd0, e.be});
          chk($sformatf("v%0d wdata", idx), MemWData, e.mwd);
        end else begin
          n_total = n_total;
        end
      end else begin
        got = 1'b0;
      end
      @(posedge clk); #1;
    end
    MemReady = 1'b0;
    if (!got) begin
      chk($sformatf("v%0d handshake_missing", idx), 32'd0, 32'd1);
    end else begin
      n_total = n_total;
    end
    // DONE cycle: the instruction is still presented and the pipeline advances here.
    @(negedge clk);
    chk($sformatf("v%0d done_stall", idx), {31'd0, StallM}, 32'd0);
    chk($sformatf("v%0d done_valid", idx), {31'd0, MemValid}, 32'd0);
    chk($sformatf("v%0d done_buserr", idx), {31'd0, BusErrM}, 32'd0);
    chk($sformatf("v%0d done_misalign", idx), {31'd0, MisalignM}, 32'd0);
    chk($sformatf("v%0d rdata", idx), ReadDataM, v.rdm);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    vec_t v;
    n_pass  = 0;
    n_total = 0;
    //          rd    wr    f3      addr          wd            rdata         lat be       mwd           we    rdm
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 0, 4'b0000, 32'h0,        1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 2, 4'b0000, 32'h0,        1'b0, 32'h0000_0080};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,        1, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0000_0080};
    vecs[4]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5, 1'b1, 32'h0000_0080};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 4'b0000, 32'h0,        1'b0, 32'hFFFF_8001};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_F00D, 1, 4'b0000, 32'h0,        1'b0, 32'h0000_F00D};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0,        32'hCAFE_F00D, 3, 4'b0000, 32'h0,        1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h1122_3344, 32'hDEAD_DEAD, 0, 4'b1111, 32'h1122_3344, 1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'h8765_4321, 0, 4'b0000, 32'h0,        1'b0, 32'h8765_4321};
    vecs[10] = '{1'b0, 1'b1, 3'b110, 32'h0000_0014, 32'h5566_7788, 32'h0,        0, 4'b1111, 32'h5566_7788, 1'b1, 32'h8765_4321};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h007F_0000, 1, 4'b0000, 32'h0,        1'b0, 32'h0000_007F};

    idle_inputs();
    MemRData = 32'd0;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ReadDataM", ReadDataM, 32'd0);
    chk("rst MemAddr", MemAddr, 32'd0);
    chk("rst MemWData", MemWData, 32'd0);
    chk("rst MemBE", {28'd0, MemBE}, 32'd0);
    chk("rst MemWE", {31'd0, MemWE}, 32'd0);
    chk("rst MemValid", {31'd0, MemValid}, 32'd0);
    chk("rst StallM", {31'd0, StallM}, 32'd0);
    chk("rst BusErrM", {31'd0, BusErrM}, 32'd0);
    chk("rst MisalignM", {31'd0, MisalignM}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_txn(i, vecs[i]);
    end

    // MemReady asserted while idle must be ignored.
    MemReady = 1'b1;
    MemRData = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("idle_ready stall", {31'd0, StallM}, 32'd0);
    chk("idle_ready valid", {31'd0, MemValid}, 32'd0);
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(negedge clk);
    chk("idle_ready rdata", ReadDataM, 32'h0000_007F);
    chk("idle_ready valid2", {31'd0, MemValid}, 32'd0);
    @(posedge clk); #1;

    // Misaligned word load at 0x101.
`ifdef MISALIGN_TRAP_EN
    MemReadM   = 1'b1;
    Funct3M    = 3'b010;
    ALUResultM = 32'h0000_0101;
    @(negedge clk);
    chk("mis idle_stall", {31'd0, StallM}, 32'd1);
    chk("mis idle_valid", {31'd0, MemValid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis done_flag", {31'd0, MisalignM}, 32'd1);
    chk("mis done_stall", {31'd0, StallM}, 32'd0);
    chk("mis done_valid", {31'd0, MemValid}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("mis pulse_end", {31'd0, MisalignM}, 32'd0);
    chk("mis no_valid", {31'd0, MemValid}, 32'd0);
    @(posedge clk); #1;
`else
    v = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0102_0304, 0, 4'b0000, 32'h0, 1'b0, 32'h0102_0304};
    run_txn(20, v);
`endif

    // Reset during BUSY, followed by a late MemReady.
    MemReadM   = 1'b1;
    Funct3M    = 3'b010;
    ALUResultM = 32'h0000_0500;
    MemRData   = 32'h1234_5678;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy valid", {31'd0, MemValid}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    MemReady = 1'b1;
    @(negedge clk);
    chk("rstbusy valid_after", {31'd0, MemValid}, 32'd0);
    chk("rstbusy stall_after", {31'd0, StallM}, 32'd0);
    chk("rstbusy rdata", ReadDataM, 32'd0);
    chk("rstbusy addr", MemAddr, 32'd0);
    @(posedge clk); #1;
    MemReady = 1'b0;
    @(negedge clk);
    chk("rstbusy idle_hold", {31'd0, MemValid}, 32'd0);
    chk("rstbusy rdata_hold", ReadDataM, 32'd0);
    @(posedge clk); #1;

    // Put non-zero load data in ReadDataM so the timeout clear is visible.
    v = '{1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 32'hA5A5_5A5A, 0, 4'b0000, 32'h0, 1'b0, 32'hA5A5_5A5A};
    run_txn(21, v);

    // Timeout: load with MemReady held low for TIMEOUT_CYCLES=4.
    MemReadM   = 1'b1;
    Funct3M    = 3'b010;
    ALUResultM = 32'h0000_0400;
    MemRData   = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("to idle_stall", {31'd0, StallM}, 32'd1);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("to busy_valid c%0d", c), {31'd0, MemValid}, 32'd1);
      chk($sformatf("to busy_buserr c%0d", c), {31'd0, BusErrM}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to done_valid", {31'd0, MemValid}, 32'd0);
    chk("to done_buserr", {31'd0, BusErrM}, 32'd1);
    chk("to done_stall", {31'd0, StallM}, 32'd0);
    chk("to done_rdata", ReadDataM, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("to pulse_end", {31'd0, BusErrM}, 32'd0);
    chk("to idle_valid", {31'd0, MemValid}, 32'd0);
    @(posedge clk); #1;

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
